// File: rtl/operand_fetch_pkg.sv
// Shared CPU definitions for the operand fetch path: data width,
// register-file geometry and the operand buffer occupancy encoding.
package operand_fetch_pkg;

    localparam int CPU_W    = 8;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Simultaneous push and pop in ONE keeps the occupancy unchanged.
    function automatic logic [1:0] fsm_next(input logic [1:0] st,
                                            input logic       push,
                                            input logic       pop);
        logic [1:0] nxt;
        nxt = st;
        case (st)
            ST_EMPTY: nxt = push ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
                if (push && !pop)
                    nxt = ST_TWO;
                else if (pop && !push)
                    nxt = ST_EMPTY;
                else
                    nxt = ST_ONE;
            end
            ST_TWO:   nxt = pop ? ST_ONE : ST_TWO;
            default:  nxt = ST_EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/operand_fetch_select.sv
// One register read port: 8:1 mux over the bank with forwarding of the
// value being written in the same cycle.
module operand_select
    import operand_fetch_pkg::*;
#(
    parameter int W = CPU_W
) (
    input  logic [NUM_REGS-1:0][W-1:0] regs,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       wr_en,
    input  logic [SEL_W-1:0]           wr_sel,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               operand
);

    always_comb begin
        operand = regs[sel];
        if (wr_en && (wr_sel == sel))
            operand = wr_data;
    end

endmodule

// File: rtl/operand_fetch.sv
// Two-entry operand-pair buffer between the register bank and the execute
// stage; state advances on the falling clock edge alongside the bank.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = CPU_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [W-1:0]     R0,
    input  logic [W-1:0]     R1,
    input  logic [W-1:0]     R2,
    input  logic [W-1:0]     R3,
    input  logic [W-1:0]     R4,
    input  logic [W-1:0]     R5,
    input  logic [W-1:0]     R6,
    input  logic [W-1:0]     R7,
    input  logic             WR_EN,
    input  logic [SEL_W-1:0] WR_SEL,
    input  logic [W-1:0]     WR_DATA,
    input  logic             REQ_VALID,
    input  logic [SEL_W-1:0] REQ_RA,
    input  logic [SEL_W-1:0] REQ_RB,
    output logic             REQ_READY,
    output logic             OP_VALID,
    output logic [W-1:0]     OP_A,
    output logic [W-1:0]     OP_B,
    input  logic             OP_READY,
    output logic [7:0]       FETCH_CNT
);

    logic [NUM_REGS-1:0][W-1:0] regs;
    logic [W-1:0] sel_a, sel_b;

    logic [1:0]   state_q, state_d;
    logic         head_q, head_d;
    logic [W-1:0] ent_a_q [DEPTH];
    logic [W-1:0] ent_a_d [DEPTH];
    logic [W-1:0] ent_b_q [DEPTH];
    logic [W-1:0] ent_b_d [DEPTH];
    logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic         op_valid_q, op_valid_d;
    logic         req_ready_q, req_ready_d;
    logic [7:0]   fetch_cnt_q, fetch_cnt_d;
    logic         push, pop, tail;

    assign regs = {R7, R6, R5, R4, R3, R2, R1, R0};

    operand_select #(.W(W)) u_sel_a (
        .regs(regs), .sel(REQ_RA), .wr_en(WR_EN), .wr_sel(WR_SEL),
        .wr_data(WR_DATA), .operand(sel_a)
    );

    operand_select #(.W(W)) u_sel_b (
        .regs(regs), .sel(REQ_RB), .wr_en(WR_EN), .wr_sel(WR_SEL),
        .wr_data(WR_DATA), .operand(sel_b)
    );

    always_comb begin
        push        = REQ_VALID && req_ready_q;
        pop         = op_valid_q && OP_READY;
        tail        = head_q ^ (state_q == ST_ONE);
        state_d     = fsm_next(state_q, push, pop);
        head_d      = pop ? ~head_q : head_q;
        ent_a_d     = ent_a_q;
        ent_b_d     = ent_b_q;
        if (push) begin
            ent_a_d[tail] = sel_a;
            ent_b_d[tail] = sel_b;
        end
        // Outputs are registered copies of the next head so they hold steady
        // under backpressure and keep their last value once the buffer empties.
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (state_d != ST_EMPTY) begin
            op_a_d = ent_a_d[head_d];
            op_b_d = ent_b_d[head_d];
        end
        op_valid_d  = (state_d != ST_EMPTY);
        req_ready_d = (state_d != ST_TWO);
        fetch_cnt_d = fetch_cnt_q + {7'd0, push};
    end

    always_ff @(negedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_EMPTY;
            head_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_valid_q  <= 1'b0;
            req_ready_q <= 1'b0;
            fetch_cnt_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_a_q[i] <= '0;
                ent_b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_valid_q  <= op_valid_d;
            req_ready_q <= req_ready_d;
            fetch_cnt_q <= fetch_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_a_q[i] <= ent_a_d[i];
                ent_b_q[i] <= ent_b_d[i];
            end
        end
    end

    assign REQ_READY = req_ready_q;
    assign OP_VALID  = op_valid_q;
    assign OP_A      = op_a_q;
    assign OP_B      = op_b_q;
    assign FETCH_CNT = fetch_cnt_q;

endmodule
